// File: rtl/gcu_buf_pkg.sv
// Shared definitions for the GCU task-buffer manager: slot state encoding.
package gcu_buf_pkg;

   // Life cycle of one buffer slot; 3-bit encoding keeps room for later states.
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOADING    = 3'd1,
      READY      = 3'd2,
      PROCESSING = 3'd3,
      WRITEBACK  = 3'd4
   } slot_state_e;

endpackage

// File: rtl/gcu_buf_slot.sv
// One buffer slot: state machine, latched task descriptor and load-request pulse.
// The current state is exported on 'state' so checkers can bind to it directly.
module gcu_buf_slot
   import gcu_buf_pkg::*;
#(
   parameter int TASK_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc,
   input  logic [TASK_W-1:0] task_in,
   input  logic              load_done,
   input  logic              take,
   input  logic              compute_done,
   input  logic              wb_done,
   output slot_state_e       state,
   output logic [TASK_W-1:0] task_q,
   output logic              load_req
);

   // Slot state advances only on the strobe matching its current state;
   // any other strobe is ignored. alloc is only raised by the top while IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         task_q   <= '0;
         load_req <= 1'b0;
      end else begin
         load_req <= alloc;
         if (alloc) begin
            task_q <= task_in;
         end
         case (state)
            IDLE:       if (alloc)        state <= LOADING;
            LOADING:    if (load_done)    state <= READY;
            READY:      if (take)         state <= PROCESSING;
            PROCESSING: if (compute_done) state <= WRITEBACK;
            WRITEBACK:  if (wb_done)      state <= IDLE;
            default:                      state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/gcu_buffer_mgr.sv
// Task-buffer manager: assigns incoming task descriptors to the lowest-index
// free slot and exposes per-slot load / compute / write-back progress.
//
// Task handshake: a descriptor transfers on a rising edge where task_valid and
// task_ready are both high. task_ready depends only on front_ready_for_task and
// registered slot state, never on task_valid. The dispatcher holds task_valid
// and task_in stable until the transfer happens.
module gcu_buffer_mgr
   import gcu_buf_pkg::*;
#(
   parameter int BUFFER_NUM     = 2,
   parameter int TASK_W         = 128,
   parameter int FRONT_ADDR_W   = 32,
   parameter int FRONT_DIM_W    = 16,
   parameter int FRONT_ADDR_LSB = 0,
   parameter int FRONT_DIM_LSB  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    task_valid,
   output logic                    task_ready,
   input  logic [TASK_W-1:0]       task_in,
   input  logic                    front_ready_for_task,
   output logic [BUFFER_NUM-1:0]   front_load_req,
   output logic [FRONT_ADDR_W-1:0] front_load_addr [BUFFER_NUM],
   output logic [FRONT_DIM_W-1:0]  front_load_dim  [BUFFER_NUM],
   input  logic [BUFFER_NUM-1:0]   front_load_done,
   output logic [BUFFER_NUM-1:0]   buf_ready_for_compute,
   input  logic [BUFFER_NUM-1:0]   buf_take,
   input  logic [BUFFER_NUM-1:0]   node_compute_done,
   input  logic [BUFFER_NUM-1:0]   writeback_done,
   output logic [TASK_W-1:0]       buf_task [BUFFER_NUM],
   output logic [BUFFER_NUM-1:0]   buf_busy
);

   slot_state_e           slot_state [BUFFER_NUM];
   logic [BUFFER_NUM-1:0] slot_idle;
   logic [BUFFER_NUM-1:0] first_idle;
   logic [BUFFER_NUM-1:0] alloc;
   logic                  idle_found;
   logic                  accept;

   // Registered-state decodes; a slot freed this edge shows idle next cycle only.
   always_comb begin
      for (int i = 0; i < BUFFER_NUM; i++) begin
         slot_idle[i]             = (slot_state[i] == IDLE);
         buf_busy[i]              = (slot_state[i] != IDLE);
         buf_ready_for_compute[i] = (slot_state[i] == READY);
      end
   end

   // Lowest-index idle slot as a one-hot vector.
   always_comb begin
      first_idle = '0;
      idle_found = 1'b0;
      for (int i = 0; i < BUFFER_NUM; i++) begin
         if (slot_idle[i] && !idle_found) begin
            first_idle[i] = 1'b1;
            idle_found    = 1'b1;
         end
      end
   end

   assign task_ready = front_ready_for_task & (|slot_idle);
   assign accept     = task_valid & task_ready;
   assign alloc      = first_idle & {BUFFER_NUM{accept}};

   for (genvar g = 0; g < BUFFER_NUM; g++) begin : g_slot
      gcu_buf_slot #(
         .TASK_W (TASK_W)
      ) u_slot (
         .clk          (clk),
         .rst_n        (rst_n),
         .alloc        (alloc[g]),
         .task_in      (task_in),
         .load_done    (front_load_done[g]),
         .take         (buf_take[g]),
         .compute_done (node_compute_done[g]),
         .wb_done      (writeback_done[g]),
         .state        (slot_state[g]),
         .task_q       (buf_task[g]),
         .load_req     (front_load_req[g])
      );

      assign front_load_addr[g] = buf_task[g][FRONT_ADDR_LSB +: FRONT_ADDR_W];
      assign front_load_dim[g]  = buf_task[g][FRONT_DIM_LSB +: FRONT_DIM_W];
   end

endmodule

// File: tb/tb_gcu_buffer_mgr.sv
// Directed bench for gcu_buffer_mgr with two slots and default field layout.
module tb_gcu_buffer_mgr;

   localparam int NB = 2;
   localparam int TW = 128;

   logic          clk;
   logic          rst_n;
   logic          task_valid;
   logic          task_ready;
   logic [TW-1:0] task_in;
   logic          front_ready_for_task;
   logic [NB-1:0] front_load_req;
   logic [31:0]   front_load_addr [NB];
   logic [15:0]   front_load_dim  [NB];
   logic [NB-1:0] front_load_done;
   logic [NB-1:0] buf_ready_for_compute;
   logic [NB-1:0] buf_take;
   logic [NB-1:0] node_compute_done;
   logic [NB-1:0] writeback_done;
   logic [TW-1:0] buf_task [NB];
   logic [NB-1:0] buf_busy;

   int total = 0;
   int bad   = 0;

   gcu_buffer_mgr #(
      .BUFFER_NUM (NB),
      .TASK_W     (TW)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .task_valid            (task_valid),
      .task_ready            (task_ready),
      .task_in               (task_in),
      .front_ready_for_task  (front_ready_for_task),
      .front_load_req        (front_load_req),
      .front_load_addr       (front_load_addr),
      .front_load_dim        (front_load_dim),
      .front_load_done       (front_load_done),
      .buf_ready_for_compute (buf_ready_for_compute),
      .buf_take              (buf_take),
      .node_compute_done     (node_compute_done),
      .writeback_done        (writeback_done),
      .buf_task              (buf_task),
      .buf_busy              (buf_busy)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Descriptor with address in [31:0], dimension in [47:32] and a tag in the top bits.
   function automatic logic [TW-1:0] make_task(input logic [31:0] addr, input logic [15:0] dim);
      logic [TW-1:0] t;
      t = '0;
      t[31:0]    = addr;
      t[47:32]   = dim;
      t[127:112] = 16'hA5A5;
      return t;
   endfunction

   // Advance one edge; inputs driven and outputs sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      task_valid = 1'b0;
      task_in = '0;
      front_ready_for_task = 1'b1;
      front_load_done = '0;
      buf_take = '0;
      node_compute_done = '0;
      writeback_done = '0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      total++; if (buf_busy !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", buf_busy); end
      total++; if (buf_ready_for_compute !== 2'b00) begin bad++; $display("FAIL reset_rfc got=%b exp=00", buf_ready_for_compute); end
      total++; if (front_load_req !== 2'b00) begin bad++; $display("FAIL reset_req got=%b exp=00", front_load_req); end
      total++; if (task_ready !== 1'b1) begin bad++; $display("FAIL reset_task_ready got=%b exp=1", task_ready); end
      total++; if (buf_task[0] !== '0 || buf_task[1] !== '0) begin bad++; $display("FAIL reset_buf_task got=%h/%h exp=0", buf_task[0], buf_task[1]); end
   endtask

   task automatic test_accept();
      task_in = make_task(32'h1, 16'h3);
      task_valid = 1'b1;
      #1;
      total++; if (task_ready !== 1'b1) begin bad++; $display("FAIL acc0_ready got=%b exp=1", task_ready); end
      tick();
      task_valid = 1'b0;
      total++; if (front_load_req !== 2'b01) begin bad++; $display("FAIL acc0_req got=%b exp=01", front_load_req); end
      total++; if (front_load_addr[0] !== 32'h1) begin bad++; $display("FAIL acc0_addr got=%h exp=1", front_load_addr[0]); end
      total++; if (front_load_dim[0] !== 16'h3) begin bad++; $display("FAIL acc0_dim got=%h exp=3", front_load_dim[0]); end
      total++; if (buf_busy !== 2'b01) begin bad++; $display("FAIL acc0_busy got=%b exp=01", buf_busy); end
      tick();
      total++; if (front_load_req !== 2'b00) begin bad++; $display("FAIL acc0_req_pulse got=%b exp=00", front_load_req); end
      task_in = make_task(32'h2, 16'h4);
      task_valid = 1'b1;
      tick();
      task_valid = 1'b0;
      total++; if (front_load_req !== 2'b10) begin bad++; $display("FAIL acc1_req got=%b exp=10", front_load_req); end
      total++; if (front_load_addr[1] !== 32'h2) begin bad++; $display("FAIL acc1_addr got=%h exp=2", front_load_addr[1]); end
      total++; if (front_load_dim[1] !== 16'h4) begin bad++; $display("FAIL acc1_dim got=%h exp=4", front_load_dim[1]); end
      total++; if (buf_busy !== 2'b11) begin bad++; $display("FAIL acc1_busy got=%b exp=11", buf_busy); end
      total++; if (buf_task[1] !== make_task(32'h2, 16'h4)) begin bad++; $display("FAIL acc1_task got=%h", buf_task[1]); end
      tick();
   endtask

   task automatic test_full();
      task_in = make_task(32'h5, 16'h6);
      task_valid = 1'b1;
      #1;
      total++; if (task_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", task_ready); end
      for (int c = 0; c < 4; c++) begin
         tick();
         total++; if (front_load_req !== 2'b00) begin bad++; $display("FAIL full_req c=%0d got=%b exp=00", c, front_load_req); end
         total++; if (buf_busy !== 2'b11 || buf_ready_for_compute !== 2'b00) begin bad++; $display("FAIL full_state c=%0d busy=%b rfc=%b exp=11/00", c, buf_busy, buf_ready_for_compute); end
      end
      task_valid = 1'b0;
      total++; if (front_load_addr[0] !== 32'h1) begin bad++; $display("FAIL full_keep_addr got=%h exp=1", front_load_addr[0]); end
   endtask

   task automatic test_out_of_state();
      // Both slots LOADING: strobes other than load_done must do nothing.
      buf_take = 2'b11;
      node_compute_done = 2'b11;
      writeback_done = 2'b11;
      tick();
      buf_take = '0;
      node_compute_done = '0;
      writeback_done = '0;
      tick();
      total++; if (buf_busy !== 2'b11 || buf_ready_for_compute !== 2'b00) begin bad++; $display("FAIL oos_loading busy=%b rfc=%b exp=11/00", buf_busy, buf_ready_for_compute); end
   endtask

   task automatic test_load_done();
      front_load_done = 2'b01;
      tick();
      front_load_done = '0;
      total++; if (buf_ready_for_compute !== 2'b01) begin bad++; $display("FAIL ld0_rfc got=%b exp=01", buf_ready_for_compute); end
      total++; if (buf_busy !== 2'b11) begin bad++; $display("FAIL ld0_busy got=%b exp=11", buf_busy); end
      total++; if (buf_task[0][31:0] !== 32'h1) begin bad++; $display("FAIL ld0_task_addr got=%h exp=1", buf_task[0][31:0]); end
      // READY slot ignores compute/writeback strobes.
      node_compute_done = 2'b01;
      writeback_done = 2'b01;
      front_load_done = 2'b10;
      tick();
      node_compute_done = '0;
      writeback_done = '0;
      front_load_done = '0;
      total++; if (buf_ready_for_compute !== 2'b11 || buf_busy !== 2'b11) begin bad++; $display("FAIL ld1_rfc rfc=%b busy=%b exp=11/11", buf_ready_for_compute, buf_busy); end
   endtask

   task automatic test_slot0_cycle();
      buf_take = 2'b01;
      tick();
      buf_take = '0;
      total++; if (buf_ready_for_compute !== 2'b10 || buf_busy !== 2'b11) begin bad++; $display("FAIL take0 rfc=%b busy=%b exp=10/11", buf_ready_for_compute, buf_busy); end
      node_compute_done = 2'b01;
      tick();
      node_compute_done = '0;
      total++; if (buf_busy !== 2'b11 || buf_ready_for_compute !== 2'b10) begin bad++; $display("FAIL comp0 busy=%b rfc=%b exp=11/10", buf_busy, buf_ready_for_compute); end
      total++; if (task_ready !== 1'b0) begin bad++; $display("FAIL comp0_ready got=%b exp=0", task_ready); end
      writeback_done = 2'b01;
      tick();
      writeback_done = '0;
      total++; if (buf_busy !== 2'b10) begin bad++; $display("FAIL wb0_busy got=%b exp=10", buf_busy); end
      total++; if (task_ready !== 1'b1) begin bad++; $display("FAIL wb0_ready got=%b exp=1", task_ready); end
      total++; if (buf_task[0] !== make_task(32'h1, 16'h3)) begin bad++; $display("FAIL wb0_task_kept got=%h", buf_task[0]); end
   endtask

   task automatic test_back_to_back();
      buf_take = 2'b10;
      tick();
      buf_take = '0;
      node_compute_done = 2'b10;
      total++; if (buf_ready_for_compute[1] !== 1'b0 || buf_busy[1] !== 1'b1) begin bad++; $display("FAIL b2b_take rfc=%b busy=%b", buf_ready_for_compute, buf_busy); end
      tick();
      node_compute_done = '0;
      writeback_done = 2'b10;
      tick();
      writeback_done = '0;
      total++; if (buf_ready_for_compute !== 2'b00 || buf_busy !== 2'b00) begin bad++; $display("FAIL b2b_done rfc=%b busy=%b exp=00/00", buf_ready_for_compute, buf_busy); end
   endtask

   task automatic test_front_not_ready();
      front_ready_for_task = 1'b0;
      task_in = make_task(32'h7, 16'h8);
      task_valid = 1'b1;
      #1;
      total++; if (task_ready !== 1'b0) begin bad++; $display("FAIL fnr_ready got=%b exp=0", task_ready); end
      tick();
      total++; if (front_load_req !== 2'b00 || buf_busy !== 2'b00) begin bad++; $display("FAIL fnr_noacc req=%b busy=%b exp=00/00", front_load_req, buf_busy); end
      task_valid = 1'b0;
      front_ready_for_task = 1'b1;
   endtask

   task automatic test_free_same_edge();
      // Fill both slots, walk slot0 to WRITEBACK.
      task_in = make_task(32'h10, 16'h11);
      task_valid = 1'b1;
      tick();
      task_in = make_task(32'h20, 16'h21);
      tick();
      task_valid = 1'b0;
      front_load_done = 2'b01;
      tick();
      front_load_done = '0;
      buf_take = 2'b01;
      tick();
      buf_take = '0;
      node_compute_done = 2'b01;
      tick();
      node_compute_done = '0;
      // Slot0 frees on the same edge a new task is offered: no accept that edge.
      task_in = make_task(32'h30, 16'h31);
      task_valid = 1'b1;
      writeback_done = 2'b01;
      tick();
      writeback_done = '0;
      total++; if (front_load_req !== 2'b00 || buf_busy !== 2'b10) begin bad++; $display("FAIL fse_noacc req=%b busy=%b exp=00/10", front_load_req, buf_busy); end
      total++; if (task_ready !== 1'b1) begin bad++; $display("FAIL fse_ready got=%b exp=1", task_ready); end
      tick();
      task_valid = 1'b0;
      total++; if (front_load_req !== 2'b01 || buf_busy !== 2'b11) begin bad++; $display("FAIL fse_acc req=%b busy=%b exp=01/11", front_load_req, buf_busy); end
      total++; if (front_load_addr[0] !== 32'h30 || front_load_dim[0] !== 16'h31) begin bad++; $display("FAIL fse_fields addr=%h dim=%h exp=30/31", front_load_addr[0], front_load_dim[0]); end
   endtask

   task automatic test_reset_mid();
      front_load_done = 2'b11;
      tick();
      front_load_done = '0;
      total++; if (buf_ready_for_compute !== 2'b11) begin bad++; $display("FAIL rm_both_ready got=%b exp=11", buf_ready_for_compute); end
      buf_take = 2'b01;
      tick();
      buf_take = '0;
      // Slot0 PROCESSING, slot1 READY; reset with strobes and a task offered.
      rst_n = 1'b0;
      task_in = make_task(32'h40, 16'h41);
      task_valid = 1'b1;
      node_compute_done = 2'b11;
      buf_take = 2'b11;
      tick();
      total++; if (buf_busy !== 2'b00 || buf_ready_for_compute !== 2'b00 || front_load_req !== 2'b00) begin bad++; $display("FAIL rm_state busy=%b rfc=%b req=%b exp=00", buf_busy, buf_ready_for_compute, front_load_req); end
      total++; if (buf_task[0] !== '0 || buf_task[1] !== '0) begin bad++; $display("FAIL rm_task got=%h/%h exp=0", buf_task[0], buf_task[1]); end
      rst_n = 1'b1;
      task_valid = 1'b0;
      node_compute_done = '0;
      buf_take = '0;
      tick();
      total++; if (buf_busy !== 2'b00 || task_ready !== 1'b1) begin bad++; $display("FAIL rm_after busy=%b ready=%b exp=00/1", buf_busy, task_ready); end
   endtask

   // Test sequence and final report
   initial begin
      test_reset();
      test_accept();
      test_full();
      test_out_of_state();
      test_load_done();
      test_slot0_cycle();
      test_back_to_back();
      test_front_not_ready();
      test_free_same_edge();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
